// File: rtl/systolic_feeder_if.sv
// Stream and grid-side signal bundle for systolic_feeder.
// Signals:
//   start/kSteps            tile request and reduction length K
//   inValid/inReady         beat handshake for aColIn/bRowIn
//   aColIn/bRowIn           one A column and one B row per beat
//   aNextOut/bNextOut       skewed operands into the grid
//   enableMul               grid advance/accumulate strobe
//   busy/done               tile status
//   stallCycles             FEED cycles without a beat (SYSTOLIC_FEEDER_STALL_COUNT_EN only)
interface systolic_feeder_if #(
  parameter int unsigned TILE    = 32,
  parameter int unsigned WIDTH_A = 6,
  parameter int unsigned WIDTH_B = 6,
  parameter int unsigned K_W     = 16
);
  logic                             start;
  logic [K_W-1:0]                   kSteps;
  logic                             inValid;
  logic                             inReady;
  logic [TILE-1:0][WIDTH_A-1:0]     aColIn;
  logic [TILE-1:0][WIDTH_B-1:0]     bRowIn;
  logic [TILE-1:0][WIDTH_A-1:0]     aNextOut;
  logic [TILE-1:0][WIDTH_B-1:0]     bNextOut;
  logic                             enableMul;
  logic                             busy;
  logic                             done;
`ifdef SYSTOLIC_FEEDER_STALL_COUNT_EN
  logic [31:0]                      stallCycles;

  modport master (
    output start, kSteps, inValid, aColIn, bRowIn,
    input  inReady, aNextOut, bNextOut, enableMul, busy, done, stallCycles
  );

  modport slave (
    input  start, kSteps, inValid, aColIn, bRowIn,
    output inReady, aNextOut, bNextOut, enableMul, busy, done, stallCycles
  );
`else
  modport master (
    output start, kSteps, inValid, aColIn, bRowIn,
    input  inReady, aNextOut, bNextOut, enableMul, busy, done
  );

  modport slave (
    input  start, kSteps, inValid, aColIn, bRowIn,
    output inReady, aNextOut, bNextOut, enableMul, busy, done
  );
`endif
endinterface

// File: rtl/systolic_feeder.sv
// Transmit side of the systolic grid A/B input: accepts one A column and one
// B row per beat, skews lane i by i advances, strobes enableMul, flushes zeros
// after the last beat and pulses done once the tile is fully accumulated.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    systolic_feeder_if slave (handshake, operands, grid outputs, status)
// Optional: define SYSTOLIC_FEEDER_STALL_COUNT_EN to add bus.stallCycles.
module systolic_feeder #(
  parameter int unsigned TILE    = 32,
  parameter int unsigned WIDTH_A = 6,
  parameter int unsigned WIDTH_B = 6,
  parameter int unsigned K_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  systolic_feeder_if.slave   bus
);

  localparam int unsigned     FC_W       = $clog2(2 * TILE) + 1;
  localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(2 * TILE - 2);
  localparam bit              SKIP_FLUSH = (TILE == 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t          state, state_d;
  logic [K_W-1:0]  k_rem, k_rem_d;
  logic [FC_W-1:0] flush_cnt, flush_cnt_d;
  logic            advance_c;
  logic            in_ready, enable_mul, busy, done;

  // Next-state, counter updates and the advance strobe
  always_comb begin
    state_d     = state;
    k_rem_d     = k_rem;
    flush_cnt_d = flush_cnt;
    advance_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          k_rem_d = bus.kSteps;
          state_d = (bus.kSteps == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (bus.inValid && in_ready) begin
          advance_c = 1'b1;
          k_rem_d   = k_rem - K_W'(1);
          if (k_rem == K_W'(1)) begin
            if (SKIP_FLUSH) begin
              state_d = DONE;
            end else begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end
        end
      end
      FLUSH: begin
        advance_c   = 1'b1;
        flush_cnt_d = flush_cnt - FC_W'(1);
        if (flush_cnt == FC_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k_rem      <= '0;
      flush_cnt  <= '0;
      in_ready   <= 1'b0;
      enable_mul <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      k_rem      <= k_rem_d;
      flush_cnt  <= flush_cnt_d;
      in_ready   <= (state_d == FEED);
      enable_mul <= advance_c;
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.enableMul = enable_mul;
  assign bus.busy      = busy;
  assign bus.done      = done;

  // Lane i: chain of i+1 registers; stage 0 takes the beat in FEED, zeros in FLUSH
  for (genvar i = 0; i < int'(TILE); i++) begin : g_lane
    logic [WIDTH_A-1:0] a_sr [i+1];
    logic [WIDTH_B-1:0] b_sr [i+1];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else if (state == DONE) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else if (advance_c) begin
        a_sr[0] <= (state == FEED) ? bus.aColIn[i] : '0;
        b_sr[0] <= (state == FEED) ? bus.bRowIn[i] : '0;
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign bus.aNextOut[i] = a_sr[i];
    assign bus.bNextOut[i] = b_sr[i];
  end

`ifdef SYSTOLIC_FEEDER_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of FEED cycles with no beat offered; cleared per tile
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      stall_cnt <= '0;
    end else if (state == FEED && !bus.inValid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stallCycles = stall_cnt;
`endif

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the systolic grid's A/B input interface.
- Accepts one A column and one B row per beat over a valid/ready stream, skews lane i by i cycles, and drives aNextOut/bNextOut plus enableMul into the grid.
- After the final beat it flushes zeros so the last products reach the bottom-right PE, then pulses done so the controller can start shift-out.

Parameters:
TILE, 32, grid dimension; number of A rows and B columns.
WIDTH_A, 6, bits per A element (EXP_IN_A+FRAC_IN_A+1).
WIDTH_B, 6, bits per B element (EXP_IN_B+FRAC_IN_B+1).
K_W, 16, width of the reduction-length counter.

Ports:
clock  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a tile; sampled only in IDLE.
kSteps  in  K_W  reduction length K (beats to accept); latched on start.
inValid  in  1  aColIn/bRowIn hold a valid beat.
inReady  out  1  feeder accepts a beat this cycle.
aColIn  in  WIDTH_A x [0:TILE-1]  A column k; element i goes to grid row i.
bRowIn  in  WIDTH_B x [0:TILE-1]  B row k; element j goes to grid column j.
aNextOut  out  WIDTH_A x [0:TILE-1]  skewed A to grid aNextIn.
bNextOut  out  WIDTH_B x [0:TILE-1]  skewed B to grid bNextIn.
enableMul  out  1  grid advance/accumulate strobe.
busy  out  1  high from the cycle after an accepted start through the done cycle.
done  out  1  one-cycle pulse; tile fully accumulated in grid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all skew registers, aNextOut, bNextOut, enableMul, inReady, busy, done and counters cleared to 0. Asserting reset mid-tile aborts the tile with no done pulse.
- States: IDLE, FEED, FLUSH, DONE.
- IDLE:
  - On start: latch kSteps into kRem.
  - kSteps!=0 goes to FEED; kSteps==0 goes to DONE.
  - start in any other state is ignored.
- advance definition:
  - In FEED, advance = inValid && inReady.
  - In FLUSH, advance = 1 every cycle.
  - In all other states, advance = 0.
- FEED:
  - inReady=1.
  - Each accepted beat decrements kRem.
  - The beat that takes kRem to 0 moves the FSM to FLUSH with flushCnt=2*TILE-2.
- Skew pipeline:
  - Lane i (A row i and B column i) is a chain of i+1 registers, shifted only on advance.
  - Stage 0 loads aColIn[i]/bRowIn[i] in FEED and all-zeros in FLUSH. Zero encoding is all-bits-zero.
  - The last stage of each chain drives aNextOut[i]/bNextOut[i].
  - When advance=0, all stages hold.
- enableMul: registered copy of advance, i.e. high exactly in the cycle following each advance. A stall in FEED therefore freezes the grid, so skew alignment is preserved under any inValid pattern.
- FLUSH:
  - inReady=0; decrement flushCnt every cycle.
  - When flushCnt reaches 1, the next state is DONE.
  - If TILE==1, skip FLUSH and go from FEED directly to DONE.
- DONE:
  - Lasts one cycle; done=1 (registered). This cycle coincides with the final enableMul pulse.
  - Skew registers are cleared to 0; next state is IDLE.
- Cycle budget with no stalls: enableMul high for exactly kSteps+2*TILE-2 consecutive cycles, ending on the done cycle.
- Latency: element i of beat k appears on aNextOut[i] i+1 advances after acceptance.
- Inputs are not sampled when inReady=0.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_STALL_COUNT_EN.
- Defined:
  - Adds output stallCycles[31:0]: counts cycles in FEED with inValid=0.
  - Cleared on reset and on each accepted start; saturates at 2^32-1.
  - Holds its value after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan (TILE=4, WIDTH_A=WIDTH_B=6 unless noted):
1. start, kSteps=1; beat A=[1,2,3,4], B=[5,6,7,8] held valid -> aNextOut[0]=1 one cycle after acceptance; aNextOut[3]=4 and bNextOut[3]=8 four cycles after; enableMul high for 7 consecutive cycles; done on the 7th; busy low next cycle.
2. kSteps=3, inValid dropped for 2 cycles between beats 1 and 2 -> enableMul low for exactly those 2 cycles; outputs hold; total enableMul-high count=9; done once.
3. kSteps=0 -> done pulses the cycle after start; enableMul never asserts; inReady stays 0.
4. reset driven low mid-FEED (after beat 1 of 3) -> all outputs 0 asynchronously before the next edge; after release, a new start with kSteps=1 completes normally with no residual data on aNextOut.
5. start pulsed again while busy -> ignored; tile completes with the original kSteps and a single done.
6. With SYSTOLIC_FEEDER_STALL_COUNT_EN defined, scenario 2 -> stallCycles=2 at done; next start clears it to 0.
